counter_uart_tx: RTL and testbench

Downstream consumer of the 8-bit programmable counter. It snapshots the counter value `q` and transmits it over a single UART TX pin as a 4-character ASCII frame: two uppercase hex digits, CR, LF, in 8N1 format. A frame is sent on an explicit request, or automatically whenever `q` differs from the last value sent. In the top level, its `tx` output drives one `uo_out` bit.

---
 rtl/counter_uart_pkg.sv | 32 +++
 rtl/counter_uart_tx_byte.sv | 130 +++++++++++++
 rtl/counter_uart_tx.sv | 146 ++++++++++++++
 tb/tb_counter_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_uart_pkg.sv
// counter_uart_pkg
// Shared constants, the per-character UART state encoding and the nibble to
// ASCII helper for the counter UART reporter.
package counter_uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Characters per report: two hex digits, CR, LF.
    localparam int FRAME_CHARS = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } frame_state_t;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] w_code;
        if (nib < 4'd10) begin
            w_code = ASCII_0 + {4'h0, nib};
        end else begin
            w_code = ASCII_A + {4'h0, nib} - 8'd10;
        end
        return w_code;
    endfunction

endpackage

// File: rtl/counter_uart_tx_byte.sv
// uart_tx_byte
// Transmits one byte in 8N1 format: start bit, 8 data bits LSB first, stop.
// A new byte may be handed over on the last cycle of the stop bit, so
// characters chain with no idle gap.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (line returns high)
//   byte_in    in   byte to send, sampled when byte_valid & byte_ready
//   byte_valid in   a byte is offered
//   byte_ready out  idle, or on the final cycle of the stop bit
//   tx         out  registered UART line, idle high
//   byte_done  out  high during the final cycle of the stop bit
module uart_tx_byte
    import counter_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx,
    output logic       byte_done
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    frame_state_t r_state;
    frame_state_t w_state_next;
    logic [15:0]  r_baud;
    logic [15:0]  w_baud_next;
    logic [2:0]   r_bit_idx;
    logic [2:0]   w_bit_idx_next;
    logic [7:0]   r_shift;
    logic [7:0]   w_shift_next;
    logic         r_tx;
    logic         w_tx_next;

    logic w_baud_last;
    logic w_accept;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign byte_done   = (r_state == STOP) && w_baud_last;
    assign byte_ready  = (r_state == IDLE) || byte_done;
    assign w_accept    = byte_valid && byte_ready;
    assign tx          = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    // The tx register is loaded with the level of the bit about to begin, so
    // the pin changes exactly on bit boundaries with no combinational path.
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_tx_next      = r_tx;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = START;
                    w_baud_next  = 16'd0;
                    w_shift_next = byte_in;
                    w_tx_next    = 1'b0;
                end
            end
            START: begin
                if (w_baud_last) begin
                    w_state_next   = DATA;
                    w_baud_next    = 16'd0;
                    w_bit_idx_next = 3'd0;
                    w_tx_next      = r_shift[0];
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            DATA: begin
                if (w_baud_last) begin
                    w_baud_next = 16'd0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_tx_next      = r_shift[1];
                    end
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    w_baud_next = 16'd0;
                    if (w_accept) begin
                        w_state_next = START;
                        w_shift_next = byte_in;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = IDLE;
                        w_tx_next    = 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/counter_uart_tx.sv
// counter_uart_tx
// Reports an 8-bit counter value over UART as "HH\r\n" (uppercase hex).
// A frame starts on an explicit send pulse or, with auto_en, whenever q
// differs from the last value reported. Requests during a frame collapse
// into a single pending frame that starts back-to-back after the current one.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; aborts any frame
//   q[7:0]   in   counter value to report
//   send     in   one-cycle request to report q
//   auto_en  in   request whenever q != last value sent
//   tx       out  UART line, idle high
//   busy     out  high while a frame is in flight
//   done     out  one-cycle pulse after the final LF stop bit
module counter_uart_tx
    import counter_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] q,
    input  logic       send,
    input  logic       auto_en,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] LAST_CHAR = 2'(FRAME_CHARS - 1);

    logic [7:0] r_snap;
    logic [7:0] w_snap_next;
    logic [7:0] r_last_sent;
    logic [7:0] w_last_sent_next;
    logic       r_pending;
    logic       w_pending_next;
    logic       r_active;
    logic       w_active_next;
    logic [1:0] r_char_idx;
    logic [1:0] w_char_idx_next;
    logic       r_done;
    logic       w_done_next;

    logic       w_req;
    logic       w_byte_ready;
    logic       w_byte_done;
    logic       w_byte_valid;
    logic [7:0] w_byte_in;
    logic       w_last_char;
    logic       w_frame_end;
    logic       w_char_step;
    logic       w_accept;
    logic [1:0] w_next_idx;
    logic [7:0] w_chars [FRAME_CHARS];

    // Characters of the frame in flight, built from the snapshot.
    for (genvar gi = 0; gi < FRAME_CHARS; gi++) begin : g_char
        if (gi == 0) begin : g_hi
            assign w_chars[gi] = hex_ascii(r_snap[7:4]);
        end else if (gi == 1) begin : g_lo
            assign w_chars[gi] = hex_ascii(r_snap[3:0]);
        end else if (gi == 2) begin : g_cr
            assign w_chars[gi] = ASCII_CR;
        end else begin : g_lf
            assign w_chars[gi] = ASCII_LF;
        end
    end

    // While a frame is in flight last_sent equals the snapshot, so an auto
    // trigger for the value already being sent is not a request.
    assign w_req       = send || (auto_en && (q != r_last_sent));
    assign w_last_char = (r_char_idx == LAST_CHAR);
    assign w_frame_end = r_active && w_byte_done && w_last_char;
    assign w_char_step = r_active && w_byte_done && !w_last_char;
    // A request arriving on the closing cycle counts the same as pending.
    assign w_accept    = (!r_active && w_req && w_byte_ready)
                       || (w_frame_end && (r_pending || w_req));
    assign w_next_idx  = r_char_idx + 2'd1;

    // The first character comes straight from q because the snapshot is
    // only loaded on this same edge.
    assign w_byte_valid = w_accept || w_char_step;
    assign w_byte_in    = w_accept ? hex_ascii(q[7:4]) : w_chars[w_next_idx];

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (w_byte_in),
        .byte_valid(w_byte_valid),
        .byte_ready(w_byte_ready),
        .tx        (tx),
        .byte_done (w_byte_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap      <= 8'h00;
            r_last_sent <= 8'h00;
            r_pending   <= 1'b0;
            r_active    <= 1'b0;
            r_char_idx  <= 2'd0;
            r_done      <= 1'b0;
        end else begin
            r_snap      <= w_snap_next;
            r_last_sent <= w_last_sent_next;
            r_pending   <= w_pending_next;
            r_active    <= w_active_next;
            r_char_idx  <= w_char_idx_next;
            r_done      <= w_done_next;
        end
    end

    always_comb begin
        w_snap_next      = r_snap;
        w_last_sent_next = r_last_sent;
        w_pending_next   = r_pending;
        w_active_next    = r_active;
        w_char_idx_next  = r_char_idx;
        w_done_next      = 1'b0;

        if (w_char_step) begin
            w_char_idx_next = w_next_idx;
        end
        if (w_frame_end) begin
            w_done_next   = 1'b1;
            w_active_next = 1'b0;
        end
        if (w_accept) begin
            w_snap_next      = q;
            w_last_sent_next = q;
            w_active_next    = 1'b1;
            w_char_idx_next  = 2'd0;
            w_pending_next   = 1'b0;
        end else if (r_active && w_req) begin
            w_pending_next = 1'b1;
        end
    end

    assign busy = r_active;
    assign done = r_done;

endmodule

// File: tb/tb_counter_uart_tx.sv
module tb_counter_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 40 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] q = 8'h00;
    logic       send = 1'b0;
    logic       auto_en = 1'b0;
    logic       tx;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    counter_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .q      (q),
        .send   (send),
        .auto_en(auto_en),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [7:0] exp_q[$];
    bit         m_busy    = 1'b0;
    bit         m_pending = 1'b0;
    bit         m_done    = 1'b0;
    int         m_left    = 0;
    logic [7:0] m_last    = 8'h00;
    bit         started   = 1'b0;
    bit         rx_flush  = 1'b0;

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    task automatic model_accept(input logic [7:0] v);
        exp_q.push_back(hexc(int'(v[7:4])));
        exp_q.push_back(hexc(int'(v[3:0])));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        m_last    = v;
        m_left    = FRAME_CYC;
        m_busy    = 1'b1;
        m_pending = 1'b0;
    endtask

    always @(posedge clk) begin
        bit req;
        bit ended;
        started = 1'b1;
        m_done  = 1'b0;
        if (rst) begin
            m_busy    = 1'b0;
            m_pending = 1'b0;
            m_left    = 0;
            m_last    = 8'h00;
            exp_q.delete();
            rx_flush  = 1'b1;
        end else begin
            req   = send || (auto_en && (q != m_last));
            ended = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    ended  = 1'b1;
                    m_done = 1'b1;
                end
            end
            if ((!m_busy && req) || (ended && (m_pending || req))) begin
                model_accept(q);
            end else if (ended) begin
                m_busy = 1'b0;
            end else if (m_busy && req) begin
                m_pending = 1'b1;
            end
        end
    end

    // ---------------- monitor: UART receiver + scoreboard ----------------
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = 8'h00;

    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_flush) begin
            rx_flush  = 1'b0;
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == CPB / 2) begin
                check("start_bit", tx, 0);
            end else if (rx_cnt == CPB / 2 + 9 * CPB) begin
                check("stop_bit", tx, 1);
                rx_active = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, rx_byte}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] rx byte 0x%02h expected 0x%02h", rx_byte, e);
                    check("rx_byte", rx_byte, e);
                end
            end else if (rx_cnt > CPB / 2 && ((rx_cnt - CPB / 2) % CPB) == 0) begin
                rx_byte = {tx, rx_byte[7:1]};
            end
        end
    end

    // Cycle-level busy / done / idle-line checks against the model.
    always @(negedge clk) begin
        if (started) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            if (!m_busy) check("tx_idle", tx, 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((m_busy || exp_q.size() != 0 || rx_active) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) check("idle_timeout", 1, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_send();
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // 1: single frame "3A\r\n"
        q = 8'h3A;
        pulse_send();
        wait_idle(1000);

        // 2: auto mode, q changes mid-frame
        do_reset();
        auto_en = 1'b1;
        repeat (10) @(negedge clk);
        q = 8'h05;
        repeat (50) @(negedge clk);
        q = 8'h06;
        wait_idle(1000);

        // 3: merged sends, q=FF
        auto_en = 1'b0;
        q = 8'hFF;
        pulse_send();
        repeat (30) @(negedge clk);
        pulse_send();
        repeat (40) @(negedge clk);
        pulse_send();
        repeat (40) @(negedge clk);
        pulse_send();
        wait_idle(1000);

        // 4: reset during char1 data bits, then auto with q=0
        q = 8'h12;
        pulse_send();
        repeat (58) @(negedge clk);
        rst = 1'b1;
        q = 8'h00;
        auto_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_tx", tx, 1);
        repeat (200) @(negedge clk);
        check("auto_q0_idle", busy, 0);

        // 5: simultaneous send and auto trigger
        q = 8'h7C;
        pulse_send();
        wait_idle(1000);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39, 0) == 0) q = 8'($urandom);
            send = ($urandom_range(59, 0) == 0);
            if ($urandom_range(299, 0) == 0) auto_en = ~auto_en;
            rst = ($urandom_range(1499, 0) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        send = 1'b0;
        auto_en = 1'b0;
        wait_idle(2000);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
